board_cursor_ctrl: RTL
======================

# board_cursor_ctrl

Input-side controller for the 8x8 board view: turns five push-buttons into a cursor position, a source/destination square selection and a one-cycle `moved` pulse that starts a view redraw. It drives the redraw-request end of the view handshake and waits for the view's `draw_done` (redraw complete) before accepting further input. It owns the current-player flag and toggles it after each completed redraw.

## Interface
- `DEBOUNCE`, 1000000: cycles a synchronised button must stay high before it registers as a press (minimum 1).
- `DB_W`, 20: width of each debounce counter; it must hold `DEBOUNCE`.
- `clk`  in  1  system clock.
- `resetn`  in  1  reset, synchronous, active-low; clock `clk`.
- `btn`  in  5  raw active-high buttons: [0] select, [1] up, [2] down, [3] left, [4] right.
- `draw_done`  in  1  one-cycle pulse from the view when a redraw completes.
- `cursor_x`, `cursor_y`  out  3 each  cursor square; x=0 is the left column, y=0 is the top row.
- `src_x`, `src_y`  out  3 each  selected source square.
- `src_valid`  out  1  a source square is held.
- `dst_x`, `dst_y`  out  3 each  destination of the last move.
- `moved`  out  1  one-cycle pulse that requests a redraw.
- `busy`  out  1  high from the `moved` cycle until `draw_done` is accepted.
- `now_player_white`  out  1  0 = black to move, 1 = white to move.

## Operation
- Each `btn` bit passes through a 2-FF synchroniser, then a per-button counter.
  - The counter increments while the synced bit is 1 and clears to 0 when it is 0.
  - It saturates at `DEBOUNCE`.
  - One press event fires on the cycle the counter goes from `DEBOUNCE-1` to `DEBOUNCE`.
  - Holding a button produces no further events.
- If several events fire in the same cycle, only one is taken. Priority: select > up > down > left > right. The rest are dropped.
- Cursor moves: up gives y-1, down gives y+1, left gives x-1, right gives x+1. Edge behaviour is set in Configuration.
- State machine, `S_IDLE`=0, `S_SRC`=1, `S_MOVE`=2, `S_WAIT_DRAW`=3:
  - `S_IDLE`: direction events move the cursor. On select: `src`←cursor, `src_valid`←1, go to `S_SRC`.
  - `S_SRC`: direction events move the cursor.
    - Select on the square equal to `src`: `src_valid`←0, go to `S_IDLE` (cancel).
    - Select on any other square: `dst`←cursor, go to `S_MOVE`.
  - `S_MOVE`: `moved`=1 and `busy`=1 for exactly this cycle. Next state is always `S_WAIT_DRAW`.
  - `S_WAIT_DRAW`: `busy`=1 and all button events are ignored. On `draw_done`: toggle `now_player_white`, `src_valid`←0, go to `S_IDLE`.
- `draw_done` in any state other than `S_WAIT_DRAW` is ignored.
- `src`/`dst` values stay valid through `S_WAIT_DRAW` so the view can read them.
- Debounce counters keep running in every state. A press that completes while busy is lost, not queued.

## Timing
- Reset values: `cursor`=(0,0), `src`=(0,0), `src_valid`=0, `dst`=(0,0), `moved`=0, `busy`=0, `now_player_white`=0, state `S_IDLE`, all synchronisers and counters 0.
- A button that rises before edge k and stays high updates the cursor/state registers at edge k+`DEBOUNCE`+2.
- `moved` rises one cycle after the select event that enters `S_MOVE`.
- `draw_done` sampled at edge m gives `busy`=0, the player toggled and `src_valid`=0 after edge m.
  - A `draw_done` in the same cycle as `moved` is ignored, because the state is not yet `S_WAIT_DRAW`.
- `resetn` low at any edge forces the reset values at that edge, even mid-move or mid-wait. No `moved` pulse is emitted afterwards.
- All outputs are registered. No combinational path from `btn` or `draw_done` to any output.

## Configuration
- `CURSOR_WRAP_EN` defined: moving past an edge wraps around (x=7 then right gives x=0; y=0 then up gives y=7). Coordinates are 3-bit modular.
- `CURSOR_WRAP_EN` undefined: the cursor saturates at 0 and 7. An event at the edge leaves the cursor unchanged but is still consumed.

## Test plan
- Debounce (`DEBOUNCE`=4): hold `btn[4]` for 10 cycles → `cursor_x` 0→1 exactly 6 cycles after the rise, with no second step. Pulse `btn[4]` for 3 cycles → no change.
- Priority: `btn[1]` and `btn[4]` rise on the same cycle with cursor (3,3) → cursor becomes (3,2). The right-press is dropped and `cursor_x` stays 3.
- Move flow: select at (1,6), move right twice, select at (3,6) → `src`=(1,6), `dst`=(3,6), `moved` high for 1 cycle, `busy` high. `draw_done` 20 cycles later → `busy`=0, `now_player_white`=1, `src_valid`=0.
- Cancel and busy: select at (2,2) twice → `src_valid` 1 then 0, no `moved`. During `S_WAIT_DRAW`, a right press → cursor unchanged. A stray `draw_done` in `S_IDLE` → player unchanged.
- Edges: cursor (0,0), press left → (7,0) with `CURSOR_WRAP_EN`, (0,0) without it. Press up at y=0 → y=7 or 0 respectively.
- Reset mid-operation: assert `resetn`=0 in `S_WAIT_DRAW` with player 1 → all outputs at reset values after that edge. A later `draw_done` → no toggle.

Source files
------------

// File: rtl/board_cursor_ctrl.sv
// Button-driven cursor/selection controller for the 8x8 board view with redraw handshake.
// Optional macro CURSOR_WRAP_EN: cursor wraps at the board edges instead of saturating.
module board_cursor_ctrl #(
  parameter int unsigned DEBOUNCE = 1000000,
  parameter int unsigned DB_W     = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] btn,
  input  logic       draw_done,
  output logic [2:0] cursor_x,
  output logic [2:0] cursor_y,
  output logic [2:0] src_x,
  output logic [2:0] src_y,
  output logic       src_valid,
  output logic [2:0] dst_x,
  output logic [2:0] dst_y,
  output logic       moved,
  output logic       busy,
  output logic       now_player_white
);

  localparam int unsigned N_BTN = 5;
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SRC       = 2'd1,
    S_MOVE      = 2'd2,
    S_WAIT_DRAW = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [N_BTN-1:0] sync1, sync2, ev;
  logic [DB_W-1:0]  cnt [N_BTN];

  logic [2:0] cx_nxt, cy_nxt, sx_nxt, sy_nxt, dx_nxt, dy_nxt;
  logic       sv_nxt, moved_nxt, busy_nxt, pw_nxt;
  logic [2:0] x_dec, x_inc, y_dec, y_inc;

  // Synchronise, debounce, and register a single-cycle press event per button
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
      ev    <= '0;
      for (int i = 0; i < int'(N_BTN); i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      for (int i = 0; i < int'(N_BTN); i++) begin
        ev[i] <= sync2[i] && (cnt[i] == DB_LAST);
        if (!sync2[i])
          cnt[i] <= '0;
        else if (cnt[i] != DB_MAX)
          cnt[i] <= cnt[i] + DB_W'(1);
      end
    end
  end

`ifdef CURSOR_WRAP_EN
  assign x_dec = cursor_x - 3'd1;
  assign x_inc = cursor_x + 3'd1;
  assign y_dec = cursor_y - 3'd1;
  assign y_inc = cursor_y + 3'd1;
`else
  assign x_dec = (cursor_x == 3'd0) ? 3'd0 : cursor_x - 3'd1;
  assign x_inc = (cursor_x == 3'd7) ? 3'd7 : cursor_x + 3'd1;
  assign y_dec = (cursor_y == 3'd0) ? 3'd0 : cursor_y - 3'd1;
  assign y_inc = (cursor_y == 3'd7) ? 3'd7 : cursor_y + 3'd1;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state            <= S_IDLE;
      cursor_x         <= '0;
      cursor_y         <= '0;
      src_x            <= '0;
      src_y            <= '0;
      src_valid        <= 1'b0;
      dst_x            <= '0;
      dst_y            <= '0;
      moved            <= 1'b0;
      busy             <= 1'b0;
      now_player_white <= 1'b0;
    end else begin
      state            <= state_nxt;
      cursor_x         <= cx_nxt;
      cursor_y         <= cy_nxt;
      src_x            <= sx_nxt;
      src_y            <= sy_nxt;
      src_valid        <= sv_nxt;
      dst_x            <= dx_nxt;
      dst_y            <= dy_nxt;
      moved            <= moved_nxt;
      busy             <= busy_nxt;
      now_player_white <= pw_nxt;
    end
  end

  // Next state; one event per cycle with select > up > down > left > right
  always_comb begin
    state_nxt = state;
    cx_nxt    = cursor_x;
    cy_nxt    = cursor_y;
    sx_nxt    = src_x;
    sy_nxt    = src_y;
    sv_nxt    = src_valid;
    dx_nxt    = dst_x;
    dy_nxt    = dst_y;
    pw_nxt    = now_player_white;
    case (state)
      S_IDLE, S_SRC: begin
        if (ev[0]) begin
          if (state == S_IDLE) begin
            sx_nxt    = cursor_x;
            sy_nxt    = cursor_y;
            sv_nxt    = 1'b1;
            state_nxt = S_SRC;
          end else if (cursor_x == src_x && cursor_y == src_y) begin
            sv_nxt    = 1'b0;
            state_nxt = S_IDLE;
          end else begin
            dx_nxt    = cursor_x;
            dy_nxt    = cursor_y;
            state_nxt = S_MOVE;
          end
        end else if (ev[1]) begin
          cy_nxt = y_dec;
        end else if (ev[2]) begin
          cy_nxt = y_inc;
        end else if (ev[3]) begin
          cx_nxt = x_dec;
        end else if (ev[4]) begin
          cx_nxt = x_inc;
        end
      end
      S_MOVE: state_nxt = S_WAIT_DRAW;
      S_WAIT_DRAW: begin
        if (draw_done) begin
          pw_nxt    = ~now_player_white;
          sv_nxt    = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Outputs registered from the upcoming state so they align with it
    moved_nxt = (state_nxt == S_MOVE);
    busy_nxt  = (state_nxt == S_MOVE) || (state_nxt == S_WAIT_DRAW);
  end

endmodule
